// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: requester handshakes and adder hookup for adder_arbiter
interface adder_arbiter_if #(parameter int DATA_WIDTH = 8);
  logic req0_valid, req0_ready, req0_op;
  logic [DATA_WIDTH-1:0] req0_a, req0_b;
  logic rsp0_valid, rsp0_ready, rsp0_over;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic req1_valid, req1_ready, req1_op;
  logic [DATA_WIDTH-1:0] req1_a, req1_b;
  logic rsp1_valid, rsp1_ready, rsp1_over;
  logic [DATA_WIDTH-1:0] rsp1_data;
  logic [DATA_WIDTH-1:0] add_data1, add_data2, add_result;
  logic add_op, add_over;
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output add_result, add_over,
    input req0_ready, rsp0_valid, rsp0_over, rsp0_data,
    input req1_ready, rsp1_valid, rsp1_over, rsp1_data,
    input add_data1, add_data2, add_op
  );
  modport slave (
    input req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input add_result, add_over,
    output req0_ready, rsp0_valid, rsp0_over, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_over, rsp1_data,
    output add_data1, add_data2, add_op
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder between two requesters; ADDER_ARB_CNT_EN adds per-requester response counters
module adder_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDER_LAT = 1
) (
  input logic clk,
  input logic rst,
  adder_arbiter_if.slave bus,
  output logic busy
`ifdef ADDER_ARB_CNT_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic last, id, grant0, grant1, take;
  logic [2:0] lat;
  // a lone requester wins; on contention the one not granted last wins
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last);
    take = id ? bus.rsp1_ready : bus.rsp0_ready;
  end
  assign bus.req0_ready = !rst && state == IDLE && grant0;
  assign bus.req1_ready = !rst && state == IDLE && grant1;
  // accept in IDLE, wait out the adder latency in EXEC, hold the response in RESP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      last <= 1'b1;
      id <= 1'b0;
      lat <= 3'd0;
      bus.add_op <= 1'b0;
      bus.add_data1 <= {DATA_WIDTH{1'b0}};
      bus.add_data2 <= {DATA_WIDTH{1'b0}};
      bus.rsp0_valid <= 1'b0;
      bus.rsp0_over <= 1'b0;
      bus.rsp0_data <= {DATA_WIDTH{1'b0}};
      bus.rsp1_valid <= 1'b0;
      bus.rsp1_over <= 1'b0;
      bus.rsp1_data <= {DATA_WIDTH{1'b0}};
`ifdef ADDER_ARB_CNT_EN
      cnt0 <= 16'd0;
      cnt1 <= 16'd0;
`endif
    end else
      case (state)
        IDLE:
          if (grant0 || grant1) begin
            bus.add_op <= grant1 ? bus.req1_op : bus.req0_op;
            bus.add_data1 <= grant1 ? bus.req1_a : bus.req0_a;
            bus.add_data2 <= grant1 ? bus.req1_b : bus.req0_b;
            id <= grant1;
            last <= grant1;
            lat <= 3'(ADDER_LAT);
            busy <= 1'b1;
            state <= EXEC;
          end
        EXEC:
          if (lat == 3'd0) begin
            if (id) begin
              bus.rsp1_data <= bus.add_result;
              bus.rsp1_over <= bus.add_over;
              bus.rsp1_valid <= 1'b1;
            end else begin
              bus.rsp0_data <= bus.add_result;
              bus.rsp0_over <= bus.add_over;
              bus.rsp0_valid <= 1'b1;
            end
            state <= RESP;
          end else
            lat <= lat - 3'd1;
        RESP:
          if (take) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
`ifdef ADDER_ARB_CNT_EN
            if (id) cnt1 <= cnt1 + 16'd1;
            else cnt0 <= cnt0 + 16'd1;
`endif
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: vector, directed and randomized scoreboard checks of adder_arbiter
module tb_adder_arbiter;
  localparam int W = 8;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int tests = 0;
  int fails = 0;
`ifdef ADDER_ARB_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif
  adder_arbiter_if #(.DATA_WIDTH(W)) bus ();
  adder_arbiter #(.DATA_WIDTH(W), .ADDER_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
`ifdef ADDER_ARB_CNT_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1)
`endif
  );
  always #5 clk = ~clk;
  // adder stand-in: registers its inputs, result appears LAT edges after sampling
  logic [W:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= bus.add_op ? {1'b0, bus.add_data1} + {1'b0, ~bus.add_data2} + (W+1)'(1)
                          : {1'b0, bus.add_data1} + {1'b0, bus.add_data2};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.add_result = pipe[LAT-1][W-1:0];
  assign bus.add_over = pipe[LAT-1][W];
  typedef struct {
    bit id;
    logic op;
    logic [W-1:0] a, b;
    int hold;
    logic [W-1:0] d;
    logic o;
  } vec_t;
  vec_t vecs [8];
  function automatic logic [W:0] ref_sum(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] nb;
    nb = op ? (W+1)'(1 << W) - {1'b0, b} : {1'b0, b};
    return {1'b0, a} + nb;
  endfunction
  function automatic logic rsp_v(input bit id);
    return id ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction
  function automatic logic [W:0] rsp_ov(input bit id);
    return id ? {bus.rsp1_over, bus.rsp1_data} : {bus.rsp0_over, bus.rsp0_data};
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic drive(input bit id, input logic v, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask
  task automatic set_rdy(input bit id, input logic r);
    if (id) bus.rsp1_ready = r;
    else bus.rsp0_ready = r;
  endtask
  task automatic do_op(input bit id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input logic [W:0] exp);
    int n;
    @(negedge clk);
    drive(id, 1'b1, op, a, b);
    set_rdy(id, hold == 0);
    #1;
    n = 0;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("req_ready_seen", 32'(n < 20), 1);
    check("ready_exclusive", 32'(bus.req0_ready && bus.req1_ready), 0);
    @(negedge clk);
    drive(id, 1'b0, ~op, ~a, ~b);
    check("busy_after_accept", 32'(busy), 1);
    n = 0;
    while (!rsp_v(id) && n < 20) begin
      @(negedge clk); n++;
    end
    check("rsp_latency", n, LAT + 1);
    check("rsp_result", 32'(rsp_ov(id)), 32'(exp));
    check("other_rsp_idle", 32'(rsp_v(!id)), 0);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid_result", 32'({rsp_v(id), rsp_ov(id)}), 32'({1'b1, exp}));
      check("hold_busy_noready", 32'({busy, bus.req0_ready, bus.req1_ready}), 32'b100);
      @(negedge clk);
    end
    set_rdy(id, 1'b1);
    @(negedge clk);
    check("released_idle", 32'({rsp_v(id), busy}), 0);
    set_rdy(id, 1'b0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int n, g;
    bit pend, pid, mlast, v0, v1, w, any;
    logic [W:0] exp, pexp;
    logic [W-1:0] a0, b0, a1, b1;
    logic op0, op1;
    vecs = '{
      '{0, 0, 8'h12, 8'h34, 0, 8'h46, 0},
      '{1, 1, 8'h05, 8'h03, 0, 8'h02, 1},
      '{1, 1, 8'h03, 8'h05, 0, 8'hFE, 0},
      '{0, 0, 8'hFF, 8'h01, 5, 8'h00, 1},
      '{1, 0, 8'hFF, 8'hFF, 0, 8'hFE, 1},
      '{0, 1, 8'h80, 8'h01, 2, 8'h7F, 1},
      '{1, 1, 8'h00, 8'h00, 0, 8'h00, 1},
      '{0, 1, 8'h00, 8'h01, 0, 8'hFF, 0}
    };
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.add_op}), 0);
    check("reset_data", 32'({bus.add_data1, bus.add_data2, bus.rsp0_data, bus.rsp1_data}), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, {vecs[i].o, vecs[i].d});
    pulse_reset();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op0 = 1'($urandom); a0 = W'($urandom); b0 = W'($urandom);
      op1 = 1'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      drive(0, 1'b1, op0, a0, b0);
      drive(1, 1'b1, op1, a1, b1);
      #1;
      n = 0;
      while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      check("cont_ready_seen", 32'(n < 20), 1);
      check("cont_exclusive", 32'(bus.req0_ready && bus.req1_ready), 0);
      check("cont_grant", 32'(bus.req1_ready), k % 2);
      g = k % 2;
      exp = g ? ref_sum(op1, a1, b1) : ref_sum(op0, a0, b0);
      @(negedge clk);
      drive(0, 1'b1, ~op0, ~a0, b0);
      drive(1, 1'b1, ~op1, a1, ~b1);
      n = 0;
      while (!rsp_v(g[0]) && n < 20) begin
        @(negedge clk); n++;
      end
      check("cont_result", 32'({rsp_v(g[0]), rsp_ov(g[0])}), 32'({1'b1, exp}));
      check("cont_other_idle", 32'(rsp_v(!g[0])), 0);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    do_op(0, 1'b0, 8'h01, 8'h01, 0, 9'h002);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'hA5, 8'h5A);
    #1;
    check("pre_reset_ready", 32'(bus.req0_ready), 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", 32'({busy, bus.rsp0_valid, bus.rsp1_valid, bus.add_op, bus.req0_ready}), 0);
    check("async_reset_data", 32'({bus.add_data1, bus.add_data2, bus.rsp0_data, bus.rsp1_data}), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dropped_no_rsp", 32'({busy, bus.rsp0_valid, bus.rsp1_valid}), 0);
    end
    drive(0, 1'b1, 1'b1, 8'h10, 8'h01);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h02);
    #1;
    check("post_reset_grant", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    n = 0;
    while (!bus.rsp0_valid && n < 20) begin
      @(negedge clk); n++;
    end
    check("post_reset_result", 32'({bus.rsp0_valid, bus.rsp0_over, bus.rsp0_data}), 32'({1'b1, 9'h10F}));
    pulse_reset();
    pend = 0; pid = 0; mlast = 1; pexp = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      v0 = 1'($urandom); v1 = 1'($urandom);
      op0 = 1'($urandom); a0 = W'($urandom); b0 = W'($urandom);
      op1 = 1'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      drive(0, v0, op0, a0, b0);
      drive(1, v1, op1, a1, b1);
      bus.rsp0_ready = $urandom_range(0, 3) != 0;
      bus.rsp1_ready = $urandom_range(0, 3) != 0;
      #1;
      any = !pend && (v0 || v1);
      w = (v0 && v1) ? !mlast : v1;
      check("rnd_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'({any && !w, any && w}));
      if (any) begin
        pend = 1; pid = w; mlast = w;
        pexp = w ? ref_sum(op1, a1, b1) : ref_sum(op0, a0, b0);
      end else if (pend) begin
        check("rnd_other_idle", 32'(rsp_v(!pid)), 0);
        if (rsp_v(pid)) begin
          check("rnd_result", 32'(rsp_ov(pid)), 32'(pexp));
          if (pid ? bus.rsp1_ready : bus.rsp0_ready) pend = 0;
        end
      end else
        check("rnd_no_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 0);
    end
`ifdef ADDER_ARB_CNT_EN
    pulse_reset();
    check("cnt_reset", 32'({cnt0, cnt1}), 0);
    for (int i = 0; i < 3; i++) do_op(0, 1'b0, W'(i), 8'h01, 0, ref_sum(1'b0, W'(i), 8'h01));
    for (int i = 0; i < 2; i++) do_op(1, 1'b1, 8'h09, W'(i), 0, ref_sum(1'b1, 8'h09, W'(i)));
    check("cnt0", 32'(cnt0), 3);
    check("cnt1", 32'(cnt1), 2);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Shares the single adder/subtractor datapath of the small processor between two requesters, for example the ALU issue path and the address-generation path. It arbitrates round-robin with valid/ready handshakes. It drives the adder operands and op from registered copies, waits out the adder's input-register latency, then returns the result and overflow to the winning requester. One operation is in flight at a time.

Parameters:
DATA_WIDTH, 8, operand/result width; must equal the adder's `DATA_WIDTH.
ADDER_LAT, 1, cycles from the adder input being sampled to its output being valid (the adder registers its inputs); legal range 1..7.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_op  input  1  0 = add, 1 = subtract (a - b).
req0_a  input  DATA_WIDTH  operand a.
req0_b  input  DATA_WIDTH  operand b.
rsp0_valid  output  1  result for requester 0 available.
rsp0_ready  input  1  requester 0 takes the result.
rsp0_data  output  DATA_WIDTH  result.
rsp0_over  output  1  adder carry/overflow bit.
req1_*, rsp1_*  same set for requester 1.
add_data1  output  DATA_WIDTH  to adder data1.
add_data2  output  DATA_WIDTH  to adder data2.
add_op  output  1  to adder op.
add_result  input  DATA_WIDTH  from adder data_o.
add_over  input  1  from adder over.
busy  output  1  high whenever not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all outputs 0, last-grant pointer = 1 (so req0 wins first), latency counter = 0, stored id = 0.
- Clocking: clk is the only clock. rst is asynchronous, active-high.
- IDLE arbitration:
  - Only one valid requester: that requester wins.
  - Both valid: the requester not granted last wins.
  - Neither valid: stay in IDLE.
  - reqN_ready is combinational, high in IDLE for the winner only, and never high for both.
- Acceptance (valid && ready at an edge):
  - Register op, a and b into add_op, add_data1 and add_data2.
  - Store the winner id and update the last-grant pointer.
  - Load the counter with ADDER_LAT and go to EXEC.
- Adder operands: add_* stay stable from acceptance until the next acceptance. They are never cleared between operations (no toggling while idle).
- EXEC:
  - At each edge, if counter == 0: capture add_result and add_over into the response registers of the stored id, set its rspN_valid, go to RESP.
  - Otherwise decrement the counter.
  - Result: rspN_valid rises ADDER_LAT+1 edges after the acceptance edge (2 for default).
- RESP:
  - rspN_valid, rspN_data and rspN_over are held stable until rspN_ready is high at an edge.
  - At that edge, clear rspN_valid and return to IDLE.
  - No requests are accepted in EXEC or RESP, so both reqN_ready are low.
  - Minimum turnaround is ADDER_LAT+3 cycles per operation.
- Response isolation: the non-selected requester's rsp_valid stays 0. rsp data registers change only on capture.
- Arithmetic: results pass through unmodified. Subtract uses the adder's two's-complement path, so over = carry out of a + (~b + 1).
- Requester inputs: no stability is required before acceptance; values are sampled only on the accept edge.
- Reset mid-operation: the in-flight operation is dropped with no response, and all outputs return to reset values immediately (asynchronously).

Optional Feature:
Macro ADDER_ARB_CNT_EN.
- Defined: adds outputs cnt0 and cnt1 (16 bits each). A counter increments on each completed response handshake for its requester, wraps 16'hFFFF -> 0, and resets to 0.
- Not defined: cnt0 and cnt1 ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Single add: req0 a=8'h12 b=8'h34 op=0, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, rsp0_data=8'h46, rsp0_over=0, busy high for 3 cycles.
- Subtract on req1: a=8'h05 b=8'h03 op=1 -> rsp1_data=8'h02, rsp1_over=1. Then a=8'h03 b=8'h05 -> rsp1_data=8'hFE, rsp1_over=0. rsp0_valid stays 0 throughout.
- Contention after reset: both valid continuously -> grants alternate 0,1,0,1. Each response is routed to the matching requester, and ready is never high for both at once.
- Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and data held stable, both req_ready low, busy high. Release -> IDLE next cycle.
- Reset mid-EXEC: rst pulsed 1 cycle after accept -> all outputs 0 asynchronously, no rsp_valid ever asserted for that op, and the next request after reset is granted to req0.
- With ADDER_ARB_CNT_EN: 3 req0 ops and 2 req1 ops -> cnt0=3, cnt1=2. Preloading near wrap and completing one op -> FFFF->0000.
